// File: rtl/manchester_tx_1553_pkg.sv
// Shared 1553B definitions: sync patterns, word field positions, symbol count,
// transmit state enum and the helper that expands a word into its 40 half-bit symbols.
// No ports; imported by the transmit stage and the half-bit timer users.
package pkg_1553b;

  localparam logic [5:0] SYNC_CMD     = 6'b111000;
  localparam logic [5:0] SYNC_DATA    = 6'b000111;
  localparam int         DATA_MSB     = 15;
  localparam int         SYNC_SEL_BIT = 16;
  localparam int         N_SYM        = 40;
  localparam int         SYM_IDX_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // Symbol 0 (first on the wire) lands in the MSB so the shifter can always
  // drive bit [N_SYM-1].
  function automatic logic [N_SYM-1:0] build_symbols(
    input logic [DATA_MSB:0] data,
    input logic              cmd_sync,
    input logic              par
  );
    logic [N_SYM-1:0] v;
    v = '0;
    v[N_SYM-1 -: 6] = cmd_sync ? SYNC_CMD : SYNC_DATA;
    for (int i = 0; i <= DATA_MSB; i++) begin
      v[2*i+3 -: 2] = {data[i], ~data[i]};
    end
    v[1:0] = {par, ~par};
    return v;
  endfunction

endpackage

// File: rtl/manchester_tx_1553_if.sv
// Word handshake between the transmit word FIFO and the Manchester transmit stage.
// Signals: word_valid (FIFO not empty), word_data (24-bit queued word),
// parity_set (parity inversion), word_ready (pop strobe from the transmitter).
interface manchester_tx_1553_if;

  logic        word_valid;
  logic [23:0] word_data;
  logic        parity_set;
  logic        word_ready;

  modport master (output word_valid, output word_data, output parity_set, input word_ready);
  modport slave  (input word_valid, input word_data, input parity_set, output word_ready);

endinterface

// File: rtl/mil1553_halfbit_timer.sv
// Half-bit cycle counter: counts 0..HALF_BIT_CYC-1 while enabled, strobes on wrap.
// Ports: clk, rst (sync, active high), clr_i (force to 0), en_i (count),
// cnt_o (current count), wrap_o (high on the last cycle of a half-bit while enabled).
module mil1553_halfbit_timer #(
  parameter int HALF_BIT_CYC = 25,
  parameter int CW           = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q;

  assign wrap_o = en_i && (cnt_q == CW'(HALF_BIT_CYC - 1));
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/manchester_tx_1553.sv
// Manchester II bi-phase 1553B word transmitter: pops a 24-bit word, sends sync,
// 16 data bits and parity as 40 half-bit symbols, then enforces an idle gap.
// Ports: clk, rst, wif (slave word handshake), tx_1553 ({TXP,TXN}), en_tx_1553,
// busy (SEND or GAP), word_done (pulse on the final cycle of each word).
module manchester_tx_1553
  import pkg_1553b::*;
#(
  parameter int HALF_BIT_CYC = 25,
  parameter int GAP_HALF     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  manchester_tx_1553_if.slave   wif,
  output logic [1:0]            tx_1553,
  output logic                  en_tx_1553,
  output logic                  busy,
  output logic                  word_done
);

  localparam int CW      = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1;
  localparam int GAP_CYC = GAP_HALF * HALF_BIT_CYC;
  localparam int GW      = $clog2(GAP_CYC + 1);

  tx_state_t             state_q, state_d;
  logic [N_SYM-1:0]      sym_q, sym_d;
  logic [SYM_IDX_W-1:0]  idx_q, idx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [1:0]            tx_q, tx_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [CW-1:0]         hb_cnt;
  logic                  hb_wrap;
  logic                  last_sym_end;
  logic                  xfer;
  logic                  par_bit;
  logic [N_SYM-1:0]      new_syms;
  logic [6:0]            unused_word_hi;

  assign unused_word_hi = wif.word_data[23:17];

  mil1553_halfbit_timer #(.HALF_BIT_CYC(HALF_BIT_CYC), .CW(CW)) u_hb_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != SEND),
    .en_i   (state_q == SEND),
    .cnt_o  (hb_cnt),
    .wrap_o (hb_wrap)
  );

  // Final cycle of symbol 39: the only SEND cycle where the next word may be popped.
  assign last_sym_end = (state_q == SEND) && (idx_q == SYM_IDX_W'(N_SYM - 1)) && hb_wrap;
  assign xfer         = wif.word_valid && wif.word_ready;
  assign par_bit      = ~(^wif.word_data[DATA_MSB:0]) ^ wif.parity_set;
  assign new_syms     = build_symbols(wif.word_data[DATA_MSB:0], wif.word_data[SYNC_SEL_BIT], par_bit);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer) state_d = SEND;
      SEND: if (last_sym_end && !xfer) state_d = GAP;
      GAP:  if (gap_q == GW'(GAP_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: pop strobe depends only on state/counters, held off during reset.
  always_comb begin
    wif.word_ready = 1'b0;
    if (!rst) begin
      wif.word_ready = (state_q == IDLE) || last_sym_end;
    end
  end

  // Datapath next state
  always_comb begin
    sym_d = sym_q;
    idx_d = idx_q;
    gap_d = '0;
    if (xfer) begin
      sym_d = new_syms;
      idx_d = '0;
    end else if (state_q == SEND && hb_wrap) begin
      sym_d = {sym_q[N_SYM-2:0], 1'b0};
      idx_d = last_sym_end ? '0 : idx_q + SYM_IDX_W'(1);
    end
    if (state_q == GAP && state_d == GAP) begin
      gap_d = gap_q + GW'(1);
    end
    en_d   = (state_d == SEND);
    tx_d   = en_d ? {sym_d[N_SYM-1], ~sym_d[N_SYM-1]} : 2'b00;
    busy_d = (state_d != IDLE);
    // One cycle early so the registered pulse lands on the word's final cycle.
    done_d = (state_q == SEND) && (idx_q == SYM_IDX_W'(N_SYM - 1)) &&
             (hb_cnt == CW'(HALF_BIT_CYC - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q  <= '0;
      idx_q  <= '0;
      gap_q  <= '0;
      tx_q   <= 2'b00;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sym_q  <= sym_d;
      idx_q  <= idx_d;
      gap_q  <= gap_d;
      tx_q   <= tx_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx_1553    = tx_q;
  assign en_tx_1553 = en_q;
  assign busy       = busy_q;
  assign word_done  = done_q;

endmodule

// File: tb/tb_manchester_tx_1553.sv
module tb_manchester_tx_1553;

  localparam int HB   = 25;
  localparam int GH   = 8;
  localparam int NSYM = 40;
  localparam int WCYC = NSYM * HB;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tx;
  logic       en, busy, done;

  manchester_tx_1553_if wif();

  manchester_tx_1553 #(.HALF_BIT_CYC(HB), .GAP_HALF(GH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wif        (wif),
    .tx_1553    (tx),
    .en_tx_1553 (en),
    .busy       (busy),
    .word_done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit trace[$];
  bit exp_q[$];
  int pop_idx[$];
  int pops, done_cnt, comp_bad;
  logic [23:0] w_dat[8];
  logic        w_ps[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock; samples #1 after the edge and logs the transmitter activity.
  task automatic tick();
    bit pop;
    int sz;
    pop = wif.word_valid && wif.word_ready;
    sz  = trace.size();
    @(posedge clk);
    #1;
    if (pop) begin
      pops++;
      pop_idx.push_back(sz);
    end
    if (en === 1'b1) begin
      trace.push_back(tx[1]);
      if (tx[0] !== ~tx[1]) comp_bad++;
      if (busy !== 1'b1) comp_bad++;
    end else if (tx !== 2'b00) begin
      comp_bad++;
    end
    if (done === 1'b1) done_cnt++;
  endtask

  // Expected wire pattern of one word, built from the framing rules.
  task automatic add_word(input logic [23:0] w, input logic ps);
    int ones;
    bit p;
    bit sym[$];
    ones = 0;
    for (int i = 0; i < 3; i++) sym.push_back(w[16]);
    for (int i = 0; i < 3; i++) sym.push_back(!w[16]);
    for (int i = 15; i >= 0; i--) begin
      sym.push_back(w[i]);
      sym.push_back(!w[i]);
      ones += int'(w[i]);
    end
    p = ((ones % 2) == 0) ^ ps;
    sym.push_back(p);
    sym.push_back(!p);
    foreach (sym[k]) repeat (HB) exp_q.push_back(sym[k]);
  endtask

  function automatic int sym_at(input int k);
    int pos;
    pos = k * HB + HB / 2;
    return (pos < trace.size()) ? int'(trace[pos]) : 7;
  endfunction

  function automatic logic [5:0] sync_seen();
    logic [5:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v = {v[4:0], sym_at(k) == 1};
    return v;
  endfunction

  // Sends w_dat[0..n-1] as one stream, refilling the FIFO at each pop.
  task automatic run_stream(input int n, input string tag);
    int guard, mism;
    wif.word_valid = 1'b1;
    wif.word_data  = w_dat[0];
    wif.parity_set = w_ps[0];
    guard = 0;
    while (wif.word_ready !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 32'(wif.word_ready), 32'd1);
    trace.delete(); exp_q.delete(); pop_idx.delete();
    pops = 0; done_cnt = 0; comp_bad = 0;
    for (int k = 0; k < n; k++) add_word(w_dat[k], w_ps[k]);
    tick();
    check({tag, "_en_rise"}, 32'(en), 32'd1);
    guard = 0;
    while (en === 1'b1 && guard < n * WCYC + 100) begin
      if (pops < n) begin
        wif.word_data  = w_dat[pops];
        wif.parity_set = w_ps[pops];
      end else begin
        wif.word_valid = 1'b0;
        wif.word_data  = 24'($urandom);
        wif.parity_set = 1'($urandom);
      end
      tick();
      guard++;
    end
    check({tag, "_en_drop"}, 32'(en), 32'd0);
    check({tag, "_en_cycles"}, 32'(trace.size()), 32'(n * WCYC));
    check({tag, "_pops"}, 32'(pops), 32'(n));
    check({tag, "_done"}, 32'(done_cnt), 32'(n));
    check({tag, "_txn_busy"}, 32'(comp_bad), 32'd0);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= trace.size() || trace[i] != exp_q[i]) mism++;
    end
    check({tag, "_wave"}, 32'(mism), 32'd0);
    for (int k = 1; k < n; k++) begin
      check({tag, "_pop_pos"}, 32'((k < pop_idx.size()) ? pop_idx[k] : -1), 32'(k * WCYC));
    end
  endtask

  // Called on the first cycle with en low: next pop must wait out the gap.
  task automatic gap_then(input logic [23:0] w, input logic ps, input string tag);
    int n;
    check({tag, "_tx_idle"}, 32'(tx), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wif.word_valid = 1'b1;
    wif.word_data  = w;
    wif.parity_set = ps;
    n = 0;
    while (wif.word_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_gap_len"}, 32'(n), 32'(GH * HB));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wif.word_valid = 1'b1;
    wif.word_data  = 24'h018001;
    wif.parity_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", 32'(tx), 32'd0);
      check("rst_en", 32'(en), 32'd0);
      check("rst_ready", 32'(wif.word_ready), 32'd0);
    end
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    #1;
    check("release_ready", 32'(wif.word_ready), 32'd1);

    // Command word 018001, normal parity
    w_dat[0] = 24'h018001; w_ps[0] = 1'b0;
    run_stream(1, "cmd");
    check("cmd_sync", 32'(sync_seen()), 32'h38);
    check("cmd_bit15", 32'(sym_at(6) * 2 + sym_at(7)), 32'd2);
    check("cmd_parity", 32'(sym_at(38) * 2 + sym_at(39)), 32'd2);

    // Gap: valid from drop cycle, data word 007FFF follows
    gap_then(24'h007FFF, 1'b0, "gap");
    w_dat[0] = 24'h007FFF; w_ps[0] = 1'b0;
    run_stream(1, "data");
    check("data_sync", 32'(sync_seen()), 32'h07);
    check("data_parity", 32'(sym_at(38) * 2 + sym_at(39)), 32'd1);

    gap_then(24'h007FFF, 1'b1, "gap2");
    w_dat[0] = 24'h007FFF; w_ps[0] = 1'b1;
    run_stream(1, "inj");
    check("inj_parity", 32'(sym_at(38) * 2 + sym_at(39)), 32'd2);

    // Two queued words, contiguous
    w_dat[0] = 24'h01A5C3; w_ps[0] = 1'b0;
    w_dat[1] = 24'h00F00F; w_ps[1] = 1'b0;
    run_stream(2, "pair");

    // Random stream
    for (int k = 0; k < 3; k++) begin
      w_dat[k] = 24'($urandom);
      w_ps[k]  = 1'($urandom);
    end
    run_stream(3, "rand");

    // Reset at symbol 10
    wif.word_valid = 1'b1;
    wif.word_data  = 24'($urandom);
    wif.parity_set = 1'b0;
    for (int i = 0; i < 400 && wif.word_ready !== 1'b1; i++) tick();
    tick();
    wif.word_valid = 1'b0;
    repeat (10 * HB + 5) tick();
    check("mid_en_before", 32'(en), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", 32'(tx), 32'd0);
    check("mid_rst_en", 32'(en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_release_ready", 32'(wif.word_ready), 32'd1);
    tick();
    check("mid_idle_en", 32'(en), 32'd0);
    check("mid_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/manchester_tx_1553.md
# manchester_tx_1553

Manchester II bi-phase transmit stage of the 1553B core. It sits directly downstream of the core's transmit word FIFO. It pops one 24-bit queued word at a time, frames it as a MIL-STD-1553B word (3-bit-time sync, 16 data bits, parity bit) and drives the differential transmitter pair and its enable. It owns bit timing, word-to-word contiguity and the minimum idle gap after a transmission ends.

## Interface
Parameters:
- HALF_BIT_CYC, 25, clk cycles per 500 ns half-bit (25 at 50 MHz); must be ≥ 2.
- GAP_HALF, 8, minimum idle half-bits after the transmitter drops (8 = 4 µs).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- parity_set  in  1  0 = odd parity (normal); 1 = inverted parity bit (error injection). Sampled at word accept.
- word_valid  in  1  FIFO holds a word (the FIFO's not-empty flag).
- word_data  in  24  [15:0] = data, MSB sent first; [16] = sync type (1 = command/status, 0 = data); [23:17] are ignored.
- word_ready  out  1  pop strobe. A transfer occurs on a cycle where word_valid && word_ready.
- tx_1553  out  2  [1] = TXP, [0] = TXN.
- en_tx_1553  out  1  transceiver enable.
- busy  out  1  high in SEND or GAP.
- word_done  out  1  one-cycle pulse on the last cycle of each word's final half-bit.

## Operation
- Reset values: tx_1553 = 2'b00, en_tx_1553 = 0, word_ready = 0, busy = 0, word_done = 0. State = IDLE; all counters = 0.
- States:
  - IDLE: word_ready = 1. On transfer → SEND.
  - SEND: serialises 40 half-bit symbols.
  - GAP: word_ready = 0. Lasts GAP_HALF × HALF_BIT_CYC cycles, then → IDLE.
- Symbol vector, 40 bits, sent index 0 first:
  - Sync: command sync = 111000; data sync = 000111.
  - Each data bit: 1 → 10, 0 → 01.
  - Parity bit, encoded the same way. P = ~^data[15:0] ^ parity_set.
- Encoding, while en_tx_1553 = 1: tx_1553[1] = current symbol and tx_1553[0] = its complement. While en_tx_1553 = 0: tx_1553 = 00.
- word_ready is a function of state and counters only, never of word_valid. In SEND it is 1 only in the final cycle of symbol 39.
- A transfer in that final cycle reloads the shift register. Symbol 0 of the next word follows with no gap: en_tx_1553 stays 1, giving contiguous words within a message.
- No transfer in that final cycle: en_tx_1553 and tx_1553 drop next cycle → GAP.
- word_valid rising during GAP is held off until GAP ends.
- word_data and parity_set are captured only on the transfer cycle. Later changes have no effect on the word in flight.
- Reset mid-word aborts immediately: outputs return to reset values at the next edge. The partial word is lost; no GAP is enforced after reset.

## Timing
- Half-bit counter runs 0..HALF_BIT_CYC−1. The symbol index advances when the counter wraps. Each symbol is held exactly HALF_BIT_CYC cycles.
- Transfer at cycle N (IDLE) → en_tx_1553 = 1 and symbol 0 are driven from cycle N+1.
- One word = 40 × HALF_BIT_CYC cycles (1000 cycles at the default).
- word_done coincides with the SEND-state word_ready cycle.
- Back-to-back words: period is exactly 40 × HALF_BIT_CYC cycles with no glitch on en_tx_1553.
- After a drop, the earliest next transfer is GAP_HALF × HALF_BIT_CYC cycles after the first cycle with en_tx_1553 = 0.
- All outputs are registered except word_ready.

## Structure
- Shared package pkg_1553b holds:
  - SYNC_CMD = 6'b111000 and SYNC_DATA = 6'b000111.
  - Word field positions (DATA_MSB, SYNC_SEL_BIT).
  - Symbol count 40.
  - The state enum {IDLE, SEND, GAP}.
- Sub-module mil1553_halfbit_timer: a half-bit cycle counter with a wrap strobe and a clear input. The receive decoder will reuse it.
- The top of the block holds the FSM, the 40-bit symbol shift register, the symbol index counter, the gap counter and the parity logic.

## Test plan
All scenarios use HALF_BIT_CYC = 25 and GAP_HALF = 8.
- Reset: hold rst for 3 cycles with word_valid = 1. Required: tx = 00, en = 0, word_ready = 0 throughout. word_ready = 1 on the first cycle after release.
- Command word 24'h018001, parity_set = 0. Required:
  - en high for exactly 1000 cycles.
  - TXP half-bits: 111000, 10, (01)×14, 10, then parity 10 (P = 1).
  - TXN is the complement of TXP; word_done pulses once.
- Data word 24'h007FFF: sync 000111 and parity 01 (P = 0). Same word with parity_set = 1: parity 10.
- Two words queued: en high for 2000 contiguous cycles. The second pop occurs on the last cycle of word 1; two word_done pulses.
- Gap: single word, then word_valid = 1 from the cycle en drops. Required: word_ready = 0 for 200 cycles, next transfer on cycle 200, en rises on cycle 201.
- Reset at symbol 10 of a word: tx = 00 and en = 0 on the next edge. After release, word_ready = 1 immediately (no GAP).
